// File: rtl/dcache_read_ctrl_if.sv
// Bundles the CPU, cache-storage and main-memory signals of the read-miss controller.
// slave = controller side, master = CPU/storage/memory side.
interface dcache_read_ctrl_if #(
  parameter int ADDR_W  = 15,
  parameter int INDEX_W = 12,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
);
  logic                      cpu_req;
  logic [ADDR_W-1:0]         cpu_addr;
  logic                      cpu_ready;
  logic [DATA_W-1:0]         cpu_rdata;
  logic                      busy;
  logic [ADDR_W-1:0]         cache_addr;
  logic                      cache_write;
  logic [DATA_W-1:0]         cache_wdata;
  logic                      cache_valid;
  logic [ADDR_W-INDEX_W-1:0] cache_tag;
  logic [DATA_W-1:0]         cache_rdata;
  logic                      mem_req;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_ack;
  logic [DATA_W-1:0]         mem_rdata;
  logic [CNT_W-1:0]          access_count;
  logic [CNT_W-1:0]          hit_count;

  modport slave (
    input  cpu_req, cpu_addr, cache_valid, cache_tag, cache_rdata, mem_ack, mem_rdata,
    output cpu_ready, cpu_rdata, busy, cache_addr, cache_write, cache_wdata,
           mem_req, mem_addr, access_count, hit_count
  );

  modport master (
    output cpu_req, cpu_addr, cache_valid, cache_tag, cache_rdata, mem_ack, mem_rdata,
    input  cpu_ready, cpu_rdata, busy, cache_addr, cache_write, cache_wdata,
           mem_req, mem_addr, access_count, hit_count
  );
endinterface

// File: rtl/dcache_read_ctrl.sv
// Direct-mapped cache read controller: tag lookup, miss fetch over req/ack, line fill, response.
// Hit answers 2 cycles after acceptance, miss 4 + memory wait cycles; requests outside IDLE are dropped.
module dcache_read_ctrl #(
  parameter int ADDR_W  = 15,
  parameter int INDEX_W = 12,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input logic             clk,
  input logic             rst,
  dcache_read_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_WAIT, FILL, RESPOND} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    access_q;
  logic [CNT_W-1:0]    hit_q;
  logic                ready_q;
  logic                busy_q;
  logic                mem_req_q;
  logic                write_q;
  logic                hit;

  assign hit = bus.cache_valid && (bus.cache_tag == addr_q[ADDR_W-1:INDEX_W]);

  // Output flops are set on the transition into their state, so they equal a decode of the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
      access_q  <= '0;
      hit_q     <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      mem_req_q <= 1'b0;
      write_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      write_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            addr_q <= bus.cpu_addr;
            busy_q <= 1'b1;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (access_q != '1) access_q <= access_q + CNT_W'(1);
          if (hit) begin
            if (hit_q != '1) hit_q <= hit_q + CNT_W'(1);
            data_q  <= bus.cache_rdata;
            rdata_q <= bus.cache_rdata;
            ready_q <= 1'b1;
            state   <= RESPOND;
          end else begin
            mem_req_q <= 1'b1;
            state     <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (bus.mem_ack) begin
            data_q    <= bus.mem_rdata;
            mem_req_q <= 1'b0;
            write_q   <= 1'b1;
            state     <= FILL;
          end
        end
        FILL: begin
          rdata_q <= data_q;
          ready_q <= 1'b1;
          state   <= RESPOND;
        end
        RESPOND: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q    <= 1'b0;
          mem_req_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_ready    = ready_q;
  assign bus.cpu_rdata    = rdata_q;
  assign bus.busy         = busy_q;
  assign bus.cache_addr   = addr_q;
  assign bus.cache_write  = write_q;
  assign bus.cache_wdata  = data_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_addr     = addr_q;
  assign bus.access_count = access_q;
  assign bus.hit_count    = hit_q;
endmodule

// File: tb/tb_dcache_read_ctrl.sv
// Bench for dcache_read_ctrl: behavioural cache storage and memory, resident-line reference model.
// Counters are built 10 bits wide so saturation is reached within a short run.
`timescale 1ns/1ps
module tb_dcache_read_ctrl;
  localparam int ADDR_W  = 15;
  localparam int INDEX_W = 12;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 10;
  localparam int TAG_W   = ADDR_W - INDEX_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_read_ctrl_if #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  dcache_read_ctrl #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Cache storage: combinational read, written on the fill strobe; not cleared by controller reset.
  logic [4095:0]      st_valid = '0;
  logic [TAG_W-1:0]   st_tag  [0:4095];
  logic [DATA_W-1:0]  st_data [0:4095];
  assign bus.cache_valid = st_valid[bus.cache_addr[INDEX_W-1:0]];
  assign bus.cache_tag   = st_tag[bus.cache_addr[INDEX_W-1:0]];
  assign bus.cache_rdata = st_data[bus.cache_addr[INDEX_W-1:0]];
  always @(posedge clk) begin
    if (bus.cache_write) begin
      st_valid[bus.cache_addr[INDEX_W-1:0]] <= 1'b1;
      st_tag[bus.cache_addr[INDEX_W-1:0]]   <= bus.cache_addr[ADDR_W-1:INDEX_W];
      st_data[bus.cache_addr[INDEX_W-1:0]]  <= bus.cache_wdata;
    end
  end

  function automatic logic [31:0] memval(input logic [ADDR_W-1:0] a);
    if (a == 15'h1005) return 32'hDEADBEEF;
    if (a == 15'h5005) return 32'h12345678;
    return 32'h9E37_0000 ^ {17'd0, a} ^ {a, 17'd0};
  endfunction

  // Reference model: which address each line holds, and the counters.
  bit               ref_valid [0:4095];
  logic [TAG_W-1:0] ref_tag   [0:4095];
  int               ref_acc;
  int               ref_hit;
  logic [31:0]      last_data;

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // mode 0: plain read; 1: stray cpu_req during MISS_WAIT; 2: reset as soon as mem_req is seen.
  task automatic do_read(input logic [ADDR_W-1:0] a, input int d, input int mode,
                         output int o_lat, output logic [31:0] o_data,
                         output int o_acc, output int o_hitc);
    int lat, mreq_n, wr_n, wait_n, idx, exp_lat;
    bit acked, bad_maddr, bad_wr, exp_hit;
    logic [31:0] rdata;
    logic [TAG_W-1:0] t;
    t = a[ADDR_W-1:INDEX_W];
    idx = int'(a[INDEX_W-1:0]);
    exp_hit = ref_valid[idx] && (ref_tag[idx] == t);
    exp_lat = exp_hit ? 2 : 4 + d;
    lat = 0; mreq_n = 0; wr_n = 0; wait_n = 0;
    acked = 0; bad_maddr = 0; bad_wr = 0; rdata = '0;
    o_lat = 0; o_data = '0; o_acc = 0; o_hitc = 0;
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    for (int i = 1; i <= 80 && lat == 0; i++) begin
      @(negedge clk);
      bus.mem_ack  = 1'b0;
      bus.cpu_req  = (mode == 1 && i == 3);
      bus.cpu_addr = (mode == 1 && i == 3) ? 15'h0001 : a;
      if (bus.cache_write) begin
        wr_n++;
        if (bus.cache_addr !== a || bus.cache_wdata !== memval(a)) bad_wr = 1;
      end
      if (bus.mem_req) begin
        mreq_n++;
        if (bus.mem_addr !== a) bad_maddr = 1;
        if (mode == 2) begin
          rst = 1'b1;
          #1;
          check("rst_mid_mem_req", bus.mem_req, 0);
          check("rst_mid_busy", bus.busy, 0);
          check("rst_mid_cache_write", bus.cache_write, 0);
          check("rst_mid_access_count", bus.access_count, 0);
          check("rst_mid_hit_count", bus.hit_count, 0);
          ref_acc = 0;
          ref_hit = 0;
          last_data = '0;
          return;
        end
        if (!acked) begin
          if (wait_n == d) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = memval(bus.mem_addr);
            acked = 1;
          end else begin
            wait_n++;
          end
        end
      end
      if (bus.cpu_ready) begin
        lat = i;
        rdata = bus.cpu_rdata;
        check("busy_at_ready", bus.busy, 1);
      end
    end
    if (lat == 0) begin
      check("read_timeout", 0, 1);
      return;
    end
    if (ref_acc < CNT_MAX) ref_acc++;
    if (exp_hit) begin
      if (ref_hit < CNT_MAX) ref_hit++;
    end else begin
      ref_valid[idx] = 1;
      ref_tag[idx] = t;
    end
    last_data = memval(a);
    check("latency", lat, exp_lat);
    check("rdata", rdata, memval(a));
    check("mem_req_cycles", mreq_n, exp_hit ? 0 : d + 1);
    check("fill_strobes", wr_n, exp_hit ? 0 : 1);
    check("mem_addr_stable", bad_maddr, 0);
    check("fill_addr_data", bad_wr, 0);
    check("access_count", bus.access_count, ref_acc);
    check("hit_count", bus.hit_count, ref_hit);
    o_lat = lat; o_data = rdata;
    o_acc = int'(bus.access_count); o_hitc = int'(bus.hit_count);
  endtask

  // Idle cycles with an optional spurious mem_ack: nothing may move.
  task automatic idle_noise(input bit ack);
    bit bad;
    bad = 0;
    @(negedge clk);
    bus.mem_ack   = ack;
    bus.mem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.busy || bus.cache_write || bus.cpu_ready || bus.mem_req) bad = 1;
    end
    check("idle_quiet", bad, 0);
    check("idle_access_count", bus.access_count, ref_acc);
    check("idle_hit_count", bus.hit_count, ref_hit);
    check("rdata_held", bus.cpu_rdata, last_data);
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                d;
    bit                hit;
    logic [31:0]       data;
    int                acc;
    int                hitc;
  } vec_t;

  vec_t vt [6];
  int lat, acc, hitc;
  logic [31:0] data;

  initial begin
    vt[0] = '{15'h1005, 3, 1'b0, 32'hDEADBEEF, 1, 0};
    vt[1] = '{15'h1005, 0, 1'b1, 32'hDEADBEEF, 2, 1};
    vt[2] = '{15'h5005, 1, 1'b0, 32'h12345678, 3, 1};
    vt[3] = '{15'h1005, 0, 1'b0, 32'hDEADBEEF, 4, 1};
    vt[4] = '{15'h1005, 0, 1'b1, 32'hDEADBEEF, 5, 2};
    vt[5] = '{15'h5005, 2, 1'b0, 32'h12345678, 6, 2};

    for (int i = 0; i < 4096; i++) ref_valid[i] = 0;
    ref_acc = 0; ref_hit = 0; last_data = '0;
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_cpu_ready", bus.cpu_ready, 0);
    check("reset_cpu_rdata", bus.cpu_rdata, 0);
    check("reset_mem_req", bus.mem_req, 0);
    check("reset_cache_write", bus.cache_write, 0);
    check("reset_access_count", bus.access_count, 0);
    check("reset_hit_count", bus.hit_count, 0);
    check("reset_addr_q", bus.cache_addr, 0);
    check("reset_data_q", bus.cache_wdata, 0);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      do_read(vt[k].addr, vt[k].d, 0, lat, data, acc, hitc);
      check("tbl_latency", lat, vt[k].hit ? 2 : 4 + vt[k].d);
      check("tbl_rdata", data, vt[k].data);
      check("tbl_access_count", acc, vt[k].acc);
      check("tbl_hit_count", hitc, vt[k].hitc);
    end

    // Stray request during a miss, then a spurious ack while idle.
    do_read(15'h2003, 4, 1, lat, data, acc, hitc);
    idle_noise(1'b1);

    for (int k = 0; k < 250; k++) begin
      logic [ADDR_W-1:0] a;
      a = {3'($urandom_range(0, 7)), 12'($urandom_range(0, 15))};
      do_read(a, int'($urandom_range(0, 3)), 0, lat, data, acc, hitc);
    end

    // Reset in the middle of a miss; the late ack must not fill or respond.
    do_read(15'h7FFF, 5, 2, lat, data, acc, hitc);
    @(negedge clk);
    rst = 1'b0;
    idle_noise(1'b1);
    do_read(15'h7FFF, 0, 0, lat, data, acc, hitc);
    check("after_reset_refetch", lat, 4);

    // Saturation: one miss then enough hits to pass all-ones.
    for (int k = 0; k < CNT_MAX + 8; k++) begin
      do_read(15'h0100, 0, 0, lat, data, acc, hitc);
    end
    check("sat_access_count", bus.access_count, CNT_MAX);
    check("sat_hit_count", bus.hit_count, CNT_MAX);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
